// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and helpers for the ddr_ctrl app-port arbiter.
// Contents: id_width() for requester-ID width, direction and slot-state enums,
// and a packed request record sized for the default configuration.
package ddr_arb_pkg;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_e;

    localparam int ARB_ADDR_W = 24;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_DQM_W  = ARB_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_DQM_W-1:0]  dqm;
    } arb_req_t;

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// ddr_arb_tag_fifo: in-order FIFO of requester IDs for outstanding reads.
// Ports: ck/rstn clock and async active-low reset; push/push_id enqueue;
// pop dequeues head_id; full, empty and count report occupancy.
// Push when full and pop when empty are ignored.
module ddr_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             ck,
    input  logic             rstn,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge ck) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_app_arbiter.sv
// ddr_app_arbiter: round-robin sharing of the single ddr_ctrl app port among
// NUM_REQ requesters, with in-order routing of read data back to its issuer.
// Ports: ck/rstn clock and async active-low reset; req_* per-requester request
// bus (packed, requester i at slice i*W +: W) with one-hot req_ready grant;
// rsp_valid/rsp_data one-hot registered read return; app_* registered request
// slot toward ddr_ctrl with app_rdy accept, app_rdata/app_rvalid read beats;
// err_orphan sticky flag for a read beat with nothing outstanding.
// Optional macro DDR_ARB_DIR_RUN_EN: prefer same-direction runs of up to
// RUN_MAX grants before switching direction, to cut bus turnarounds.
module ddr_app_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int DQM_W      = (DATA_W / 8 < 1) ? 1 : DATA_W / 8,
    parameter int MAX_RD_OUT = 8,
    parameter int RUN_MAX    = 4
) (
    input  logic                      ck,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*DQM_W-1:0]  req_dqm,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      app_req,
    output logic                      app_we,
    output logic [ADDR_W-1:0]         app_addr,
    output logic [DATA_W-1:0]         app_wdata,
    output logic [DQM_W-1:0]          app_dqm,
    input  logic                      app_rdy,
    input  logic [DATA_W-1:0]         app_rdata,
    input  logic                      app_rvalid,
    output logic                      err_orphan
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_RD_OUT) + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || RUN_MAX < 1 || (MAX_RD_OUT & (MAX_RD_OUT - 1)) != 0) begin : g_bad_cfg
        $error("ddr_app_arbiter: unsupported parameter set");
    end

    slot_e              slot_q, slot_d;
    logic [ID_W-1:0]    rr_ptr, gnt_id, head_id;
    logic [NUM_REQ-1:0] elig, cand, rsp_next;
    logic [CNT_W-1:0]   rd_cnt;
    logic               slot_free, gnt_vld, fifo_full, fifo_empty, push, pop;

    assign app_req   = (slot_q == SLOT_PENDING);
    assign slot_free = !app_req || app_rdy;
    // Eligibility sees the read count before any same-cycle pop.
    assign elig      = req_valid & (req_we | {NUM_REQ{rd_cnt < CNT_W'(MAX_RD_OUT)}});
    assign push      = gnt_vld && !req_we[gnt_id] && !fifo_full;
    assign pop       = app_rvalid && !fifo_empty;

`ifdef DDR_ARB_DIR_RUN_EN
    localparam int RUN_W = $clog2(RUN_MAX + 1);

    dir_e               last_dir, gnt_dir;
    logic [RUN_W-1:0]   run_cnt;
    logic [NUM_REQ-1:0] same_dir, opp_dir;

    assign same_dir = elig & ((last_dir == DIR_WR) ? req_we : ~req_we);
    assign opp_dir  = elig & ~same_dir;
    assign gnt_dir  = req_we[gnt_id] ? DIR_WR : DIR_RD;

    // run_cnt==0 means no grant yet since reset, so no direction is preferred.
    always_comb begin
        cand = elig;
        if (run_cnt != '0)
            cand = (run_cnt < RUN_W'(RUN_MAX)) ? ((|same_dir) ? same_dir : elig)
                                               : ((|opp_dir) ? opp_dir : elig);
    end

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            last_dir <= DIR_RD;
            run_cnt  <= '0;
        end else if (gnt_vld) begin
            last_dir <= gnt_dir;
            run_cnt  <= (run_cnt != '0 && gnt_dir == last_dir)
                        ? ((run_cnt < RUN_W'(RUN_MAX)) ? run_cnt + 1'b1 : run_cnt)
                        : RUN_W'(1);
        end
    end
`else
    assign cand = elig;
`endif

    // Scan from the lowest priority down so the first candidate at or after
    // rr_ptr is the last one written.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rstn && slot_free && cand[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        if (gnt_vld) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        rsp_next = '0;
        if (pop) rsp_next[head_id] = 1'b1;
    end

    always_comb slot_d = gnt_vld ? SLOT_PENDING : (app_rdy ? SLOT_EMPTY : slot_q);

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            slot_q     <= SLOT_EMPTY;
            app_we     <= 1'b0;
            app_addr   <= '0;
            app_wdata  <= '0;
            app_dqm    <= '0;
            rr_ptr     <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            slot_q <= slot_d;
            if (gnt_vld) begin
                app_we    <= req_we[gnt_id];
                app_addr  <= req_addr[int'(gnt_id) * ADDR_W +: ADDR_W];
                app_wdata <= req_wdata[int'(gnt_id) * DATA_W +: DATA_W];
                app_dqm   <= req_dqm[int'(gnt_id) * DQM_W +: DQM_W];
                rr_ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            rsp_valid  <= rsp_next;
            rsp_data   <= app_rvalid ? app_rdata : rsp_data;
            err_orphan <= err_orphan || (app_rvalid && fifo_empty);
        end
    end

    ddr_arb_tag_fifo #(
        .DEPTH (MAX_RD_OUT),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .ck      (ck),
        .rstn    (rstn),
        .push    (push),
        .push_id (gnt_id),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rd_cnt)
    );

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// tb_ddr_app_arbiter: self-checking bench for ddr_app_arbiter against a
// transaction-level model of arbitration, read tagging and a ddr_ctrl stub.
module tb_ddr_app_arbiter;
    localparam int N = 4, AW = 24, DW = 32, MW = 4, MAXR = 8, RUNM = 4;

    logic ck = 1'b0, rstn = 1'b0;
    logic [N-1:0] req_valid = '0, req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*MW-1:0] req_dqm = '0;
    logic app_rdy = 1'b0, app_rvalid = 1'b0;
    logic [DW-1:0] app_rdata = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [DW-1:0] rsp_data, app_wdata;
    logic app_req, app_we, err_orphan;
    logic [AW-1:0] app_addr;
    logic [MW-1:0] app_dqm;

    int total = 0, bad = 0;

    // reference model state
    bit m_req, m_we, m_orphan, m_last_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rsp_d;
    logic [MW-1:0] m_dqm;
    logic [N-1:0] m_rsp_v;
    int m_rr, m_cnt, m_run, ddr_pending;
    int m_tags[$];

    ddr_app_arbiter dut (
        .ck(ck), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dqm(req_dqm), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .app_req(app_req), .app_we(app_we), .app_addr(app_addr),
        .app_wdata(app_wdata), .app_dqm(app_dqm), .app_rdy(app_rdy), .app_rdata(app_rdata),
        .app_rvalid(app_rvalid), .err_orphan(err_orphan)
    );

    always #5 ck = ~ck;

    function automatic int exp_grant();
        bit [N-1:0] el, pref, same, opp;
        if (!rstn || (m_req && !app_rdy)) return -1;
        for (int i = 0; i < N; i++) el[i] = req_valid[i] && (req_we[i] || m_cnt < MAXR);
        pref = el;
`ifdef DDR_ARB_DIR_RUN_EN
        for (int i = 0; i < N; i++) begin
            same[i] = el[i] && (req_we[i] == m_last_we);
            opp[i]  = el[i] && (req_we[i] != m_last_we);
        end
        if (m_run > 0) pref = (m_run < RUNM) ? ((same != 0) ? same : el) : ((opp != 0) ? opp : el);
`else
        same = '0;
        opp = '0;
`endif
        for (int k = 0; k < N; k++) if (pref[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic model_clear();
        m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_dqm = '0;
        m_rsp_v = '0; m_rsp_d = '0; m_orphan = 0; m_rr = 0; m_cnt = 0;
        m_last_we = 0; m_run = 0; ddr_pending = 0;
        m_tags.delete();
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_dqm[i*MW +: MW] = m;
    endtask

    task automatic drive_ret(input bit want, input logic [DW-1:0] d);
        if (want && ddr_pending > 0) begin
            app_rvalid = 1'b1;
            app_rdata = d;
            ddr_pending--;
        end else app_rvalid = 1'b0;
    endtask

    // One clock: check every output at the negedge against the model, then
    // advance the model on the posedge. Returns the expected grant (or -1).
    task automatic cycle(output int g);
        logic [N-1:0] er;
        int t;
        @(negedge ck);
        g = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        total++;
        if (req_ready !== er) begin
            bad++;
            $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, er, $time);
        end
        total++;
        if ({app_req, app_we, app_addr, app_wdata, app_dqm} !== {m_req, m_we, m_addr, m_wdata, m_dqm}) begin
            bad++;
            $display("FAIL app_slot got=%b/%b/%h/%h/%h exp=%b/%b/%h/%h/%h t=%0t", app_req, app_we, app_addr,
                     app_wdata, app_dqm, m_req, m_we, m_addr, m_wdata, m_dqm, $time);
        end
        total++;
        if (rsp_valid !== m_rsp_v || (m_rsp_v != 0 && rsp_data !== m_rsp_d)) begin
            bad++;
            $display("FAIL rsp got=%b/%h exp=%b/%h t=%0t", rsp_valid, rsp_data, m_rsp_v, m_rsp_d, $time);
        end
        total++;
        if (err_orphan !== m_orphan) begin
            bad++;
            $display("FAIL err_orphan got=%b exp=%b t=%0t", err_orphan, m_orphan, $time);
        end
        @(posedge ck);
        if (m_req && app_rdy && !m_we) ddr_pending++;
        m_rsp_v = '0;
        if (app_rvalid) begin
            if (m_tags.size() > 0) begin
                t = m_tags.pop_front();
                m_rsp_v[t] = 1'b1;
                m_rsp_d = app_rdata;
                m_cnt--;
            end else m_orphan = 1;
        end
        if (g >= 0) begin
            m_req = 1; m_we = req_we[g];
            m_addr = req_addr[g*AW +: AW]; m_wdata = req_wdata[g*DW +: DW]; m_dqm = req_dqm[g*MW +: MW];
            if (!m_we) begin
                m_cnt++;
                m_tags.push_back(g);
            end
            m_rr = (g + 1) % N;
            m_run = (m_run > 0 && m_we == m_last_we) ? ((m_run < RUNM) ? m_run + 1 : m_run) : 1;
            m_last_we = m_we;
        end else if (app_rdy) m_req = 0;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; req_we = '0; app_rdy = 0; app_rvalid = 0; app_rdata = '0;
        rstn = 0;
        @(posedge ck);
        #1;
        model_clear();
        rstn = 1;
    endtask

    task automatic test_reset();
        int g;
        rstn = 0;
        req_valid = '1; req_we = '1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_data, app_req, app_we, app_addr, app_wdata, app_dqm, err_orphan} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%h/%b/%h exp=0", req_ready, rsp_valid, rsp_data, app_req, app_addr);
        end
        do_reset();
        cycle(g);
    endtask

    task automatic test_rr_writes();
        int g;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        do_reset();
        app_rdy = 1;
        for (int i = 0; i < N; i++) set_req(i, 1, AW'('h1000 + i), DW'('hC0DE0000 + i), MW'(i + 1));
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            cycle(g);
            total++;
            if (app_req !== 1'b1 || app_addr !== AW'('h1000 + exp_id[c])) begin
                bad++;
                $display("FAIL rr_order c=%0d got=%b/%h exp=1/%h", c, app_req, app_addr, AW'('h1000 + exp_id[c]));
            end
        end
        req_valid = '0;
        cycle(g);
    endtask

    task automatic test_read_return();
        int g;
        do_reset();
        app_rdy = 1;
        set_req(1, 0, 'h100, '0, '0);
        req_valid = 4'b0010;
        cycle(g);
        set_req(3, 0, 'h200, '0, '0);
        req_valid = 4'b1000;
        cycle(g);
        req_valid = '0;
        drive_ret(1, 32'hAAAA);
        cycle(g);
        total++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'hAAAA) begin
            bad++;
            $display("FAIL read_ret1 got=%b/%h exp=0010/0000aaaa", rsp_valid, rsp_data);
        end
        drive_ret(1, 32'hBBBB);
        cycle(g);
        total++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'hBBBB) begin
            bad++;
            $display("FAIL read_ret2 got=%b/%h exp=1000/0000bbbb", rsp_valid, rsp_data);
        end
        drive_ret(0, '0);
        cycle(g);
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL rsp_pulse got=%b exp=0000", rsp_valid);
        end
    endtask

    task automatic test_hold();
        int g;
        do_reset();
        set_req(0, 1, 'h0AB, 32'h12345678, 4'h5);
        set_req(1, 1, 'h0CD, 32'h9ABCDEF0, 4'hA);
        req_valid = 4'b0001;
        cycle(g);
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cycle(g);
            total++;
            if (app_req !== 1'b1 || app_addr !== 24'h0AB || app_wdata !== 32'h12345678 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL hold c=%0d got=%b/%h/%h/%b exp=1/0000ab/12345678/0000", c, app_req, app_addr, app_wdata, req_ready);
            end
        end
        app_rdy = 1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL hold_release got=%b exp=0010", req_ready);
        end
        cycle(g);
        req_valid = '0;
        total++;
        if (app_addr !== 24'h0CD || app_req !== 1'b1) begin
            bad++;
            $display("FAIL hold_next got=%b/%h exp=1/0000cd", app_req, app_addr);
        end
        cycle(g);
    endtask

    task automatic test_read_limit();
        int g;
        do_reset();
        app_rdy = 1;
        req_valid = 4'b0001;
        for (int c = 0; c < MAXR; c++) begin
            set_req(0, 0, AW'('h300 + c), '0, '0);
            cycle(g);
        end
        set_req(2, 1, 'h777, 32'h5555AAAA, 4'hF);
        req_valid = 4'b0101;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL limit_write got=%b exp=0100", req_ready);
        end
        cycle(g);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL limit_block got=%b exp=0000", req_ready);
        end
        cycle(g);
        drive_ret(1, 32'h0F0F0F0F);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL limit_nobypass got=%b exp=0000", req_ready);
        end
        cycle(g);
        drive_ret(0, '0);
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL limit_resume got=%b exp=0001", req_ready);
        end
        cycle(g);
        req_valid = '0;
        cycle(g);
    endtask

    task automatic test_orphan_and_reset();
        int g;
        do_reset();
        app_rvalid = 1;
        app_rdata = 32'hDEAD;
        cycle(g);
        app_rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(g);
            total++;
            if (err_orphan !== 1'b1 || rsp_valid !== 4'b0000) begin
                bad++;
                $display("FAIL orphan c=%0d got=%b/%b exp=1/0000", c, err_orphan, rsp_valid);
            end
        end
        app_rdy = 1;
        for (int i = 0; i < N; i++) set_req(i, i[0], AW'('h40 + i), DW'(i * 3 + 1), 4'hC);
        req_valid = '1;
        for (int c = 0; c < 3; c++) cycle(g);
        #2;
        rstn = 0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_data, app_req, app_we, app_addr, app_wdata, app_dqm, err_orphan} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%h/%b/%h/%b exp=0", req_ready, rsp_valid, rsp_data, app_req,
                     app_addr, err_orphan);
        end
        do_reset();
        cycle(g);
    endtask

    task automatic test_random();
        int g;
        bit pend[N];
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, MW'($urandom));
                end
                req_valid[i] = pend[i];
            end
            app_rdy = ($urandom_range(0, 3) != 0);
            drive_ret($urandom_range(0, (c < 400) ? 4 : 1) == 0, $urandom);
            cycle(g);
            if (g >= 0) pend[g] = 0;
        end
        req_valid = '0;
        app_rdy = 1;
        for (int c = 0; c < 20; c++) begin
            drive_ret(1, $urandom);
            cycle(g);
        end
        app_rvalid = 0;
    endtask

`ifdef DDR_ARB_DIR_RUN_EN
    task automatic test_dir_run();
        int g;
        int pat[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        do_reset();
        app_rdy = 1;
        for (int i = 0; i < N; i++) set_req(i, i < 2, AW'('h500 + i), DW'(i), 4'hF);
        req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            drive_ret(1, $urandom);
            cycle(g);
            total++;
            if (app_we !== ((c / 4) % 2 == 0) || app_addr !== AW'('h500 + pat[c % 8])) begin
                bad++;
                $display("FAIL dir_run c=%0d got=%b/%h exp=%b/%h", c, app_we, app_addr, (c / 4) % 2 == 0,
                         AW'('h500 + pat[c % 8]));
            end
        end
        req_valid = '0;
        app_rvalid = 0;
        cycle(g);
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_rr_writes();
        test_read_return();
        test_hold();
        test_read_limit();
        test_orphan_and_reset();
        test_random();
`ifdef DDR_ARB_DIR_RUN_EN
        test_dir_run();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
